// File: rtl/bi_link_dir_ctrl.sv
// Direction controller for a shared bidirectional channel between ends A and B.
// It grants ownership to one end at a time, bounds bursts while the other end
// waits, and inserts driverless turnaround cycles on every direction change.
module bi_link_dir_ctrl #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TURN_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        req_b,
  output logic        sel_a,
  output logic        sel_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        dir,
  output logic [15:0] turn_cnt
);

  localparam int unsigned BURST_W = 8;
  localparam int unsigned TURN_W  = 4;

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [TURN_W-1:0]  TURN_LAST  = TURN_W'(TURN_CYC - 1);

  // Encoding puts each drive enable on its own state bit, so sel_a/sel_b come
  // straight off a flop and cannot glitch.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    OWN_A = 3'b001,
    OWN_B = 3'b010,
    TURN  = 3'b100
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [BURST_W-1:0]  burst_q;
  logic [TURN_W-1:0]   turn_q;
  logic                enter_own;
  logic                enter_turn;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection: round robin on ties, forced handover after a full burst
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = dir ? OWN_B : OWN_A;
        end else if (req_a) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          state_d = req_b ? TURN : IDLE;
        end else if (req_b && (burst_q == BURST_LAST)) begin
          state_d = TURN;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_d = req_a ? TURN : IDLE;
        end else if (req_a && (burst_q == BURST_LAST)) begin
          state_d = TURN;
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          if (dir ? req_b : req_a) begin
            state_d = dir ? OWN_B : OWN_A;
          end else if (dir ? req_a : req_b) begin
            state_d = dir ? OWN_A : OWN_B;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore drive enables from the state bits; grants qualify them with the request
  always_comb begin
    sel_a = state_q[0];
    sel_b = state_q[1];
    gnt_a = state_q[0] & req_a;
    gnt_b = state_q[1] & req_b;
  end

  assign enter_own  = ((state_d == OWN_A) || (state_d == OWN_B)) && (state_d != state_q);
  assign enter_turn = (state_d == TURN) && (state_q != TURN);

  // Burst and turnaround counters; burst holds at its last value so a late
  // competing request still triggers a handover on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= '0;
      turn_q  <= '0;
    end else begin
      if (enter_own) begin
        burst_q <= '0;
      end else if (((state_q == OWN_A) || (state_q == OWN_B)) && (burst_q != BURST_LAST)) begin
        burst_q <= burst_q + BURST_W'(1);
      end
      if (enter_turn) begin
        turn_q <= '0;
      end else if (state_q == TURN) begin
        turn_q <= turn_q + TURN_W'(1);
      end
    end
  end

  // Last owner direction and saturating turnaround statistic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir      <= 1'b0;
      turn_cnt <= '0;
    end else begin
      if (enter_own) begin
        dir <= (state_d == OWN_A);
      end
      if (enter_turn && (turn_cnt != 16'hFFFF)) begin
        turn_cnt <= turn_cnt + 16'(1);
      end
    end
  end

endmodule

// File: doc/bi_link_dir_ctrl.md
BI_LINK_DIR_CTRL -- requirements
Module: bi_link_dir_ctrl

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: max consecutive owned cycles per side while the other side requests; legal 1..255.
REQ-002 SHALL have parameter TURN_CYC, default 1: dead cycles with no driver on every direction change; legal 1..15.
REQ-003 SHALL run on one clock and use an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port req_a, input, 1: end A has data for the shared 32-bit bidirectional channel; held high while pending.
REQ-007 SHALL have port req_b, input, 1: same for end B.
REQ-008 SHALL have port sel_a, output, 1: drive enable for end A's channel tristate.
REQ-009 SHALL have port sel_b, output, 1: drive enable for end B's channel tristate.
REQ-010 SHALL have port gnt_a, output, 1: A transfers one word this cycle.
REQ-011 SHALL have port gnt_b, output, 1: B transfers one word this cycle.
REQ-012 SHALL have port dir, output, 1: 1 = last/current owner A, 0 = B.
REQ-013 SHALL have port turn_cnt, output, 16: saturating count of entries into TURN.

Function
REQ-014 SHALL implement FSM states IDLE, OWN_A, OWN_B, TURN; state, burst counter, turnaround counter, dir and turn_cnt registered on clk.
REQ-015 SHALL decode sel_a = (state==OWN_A) and sel_b = (state==OWN_B), Moore, glitch-free from the state register.
REQ-016 SHALL drive gnt_a = sel_a & req_a and gnt_b = sel_b & req_b, combinational.
REQ-017 IDLE, req_a only: next OWN_A. req_b only: next OWN_B. Both: next OWN of the side opposite dir (round robin). Neither: stay.
REQ-018 IDLE grant latency SHALL be 1 cycle: req sampled high at edge N, sel high after edge N.
REQ-019 Entering OWN_x SHALL clear the burst counter and set dir to x; the counter increments each cycle in OWN_x.
REQ-020 OWN_x, req_x low: next TURN if other side requests, else IDLE.
REQ-021 OWN_x, req_x high, other requests, burst counter == MAX_BURST-1: next TURN (forced handover).
REQ-022 OWN_x otherwise: stay; with no competing request ownership is unbounded and the burst counter saturates.
REQ-023 TURN SHALL last exactly TURN_CYC cycles with sel_a=sel_b=0, then go to OWN of the side opposite dir if it requests, else OWN of dir side if it requests, else IDLE.
REQ-024 turn_cnt SHALL increment on each entry into TURN and saturate at 16'hFFFF.
REQ-025 sel_a and sel_b SHALL never be high in the same cycle.
REQ-026 Between sel_a falling and sel_b rising (or vice versa) SHALL be at least min(TURN_CYC, 1 IDLE cycle) driverless cycles.
REQ-027 MAX_BURST=1 with both requesting SHALL alternate ownership every cycle with TURN_CYC dead cycles between.
REQ-028 A request dropping during TURN SHALL be honoured per REQ-023; a request rising during TURN SHALL be considered at TURN exit.

Reset
REQ-029 While rst_n low, SHALL force state IDLE, sel_a=sel_b=0, gnt_a=gnt_b=0, dir=0 (B), counters 0, immediately and without a clock edge.
REQ-030 Reset asserted mid-OWN or mid-TURN SHALL release the channel in the same cycle; the first grant after deassertion follows REQ-017 with dir=0, so A wins a tie.

Verification
REQ-031 Reset, req_a=req_b=1 from cycle 0 with defaults -> sel_a cycles 1-8, dead cycle 9, sel_b cycles 10-17, dead cycle 18, sel_a from 19; turn_cnt=2 at cycle 19.
REQ-032 req_a only, held 20 cycles then dropped -> sel_a high 20 cycles, then IDLE, turn_cnt stays 0.
REQ-033 TURN_CYC=3, A owning, req_a drops while req_b=1 -> exactly 3 cycles sel_a=sel_b=0, then sel_b=1.
REQ-034 rst_n asserted asynchronously mid-OWN_B -> sel_b low before next clk edge; after release, req_a=req_b=1 -> sel_a first.
REQ-035 MAX_BURST=1, TURN_CYC=1, both requesting 10 cycles -> pattern A,dead,B,dead,...; no cycle with both sel high (assertion on every run).
REQ-036 Force turn_cnt near 16'hFFFF via long alternation -> value holds at 16'hFFFF.
